// File: rtl/of_pkg.sv
// Shared defaults and the issue-slot record for the operand-fetch stage.
package of_pkg;

  localparam int REG_WIDTH_DEF = 32;
  localparam int REG_COUNT_DEF = 16;
  localparam int OP_WIDTH_DEF  = 8;
  localparam int AW_DEF        = $clog2(REG_COUNT_DEF);

  typedef struct packed {
    logic [OP_WIDTH_DEF-1:0]  op;
    logic [REG_WIDTH_DEF-1:0] a;
    logic [REG_WIDTH_DEF-1:0] b;
    logic [AW_DEF-1:0]        rd;
    logic                     rd_we;
  } issue_t;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write tracker: one busy bit per register, set wins over clear,
// with writeback-aware lookups for the three indices of an incoming instruction.
module scoreboard #(
  parameter int  REG_COUNT = 16,
  localparam int AW        = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_idx,
  input  logic                 clr_en,
  input  logic [AW-1:0]        clr_idx,
  input  logic [AW-1:0]        look_idx0,
  input  logic [AW-1:0]        look_idx1,
  input  logic [AW-1:0]        look_idx2,
  output logic                 ebusy0,
  output logic                 ebusy1,
  output logic                 ebusy2,
  output logic [REG_COUNT-1:0] busy_mask
);

  logic [REG_COUNT-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    // A new producer issued this cycle outranks the writeback retiring the old one
    if (set_en) busy_d[set_idx] = 1'b1;

    ebusy0 = busy_q[look_idx0] && !(clr_en && (clr_idx == look_idx0));
    ebusy1 = busy_q[look_idx1] && !(clr_en && (clr_idx == look_idx1));
    ebusy2 = busy_q[look_idx2] && !(clr_en && (clr_idx == look_idx2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_mask = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Issue/operand-fetch stage: hazard check against pending writes, writeback
// bypass, and a single registered valid/ready slot towards execute.
module operand_fetch
  import of_pkg::*;
#(
  parameter int  REG_WIDTH = REG_WIDTH_DEF,
  parameter int  REG_COUNT = REG_COUNT_DEF,
  parameter int  OP_WIDTH  = OP_WIDTH_DEF,
  localparam int AW        = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_WIDTH-1:0]  in_op,
  input  logic [AW-1:0]        in_rs1,
  input  logic [AW-1:0]        in_rs2,
  input  logic                 in_uses_rs1,
  input  logic                 in_uses_rs2,
  input  logic [AW-1:0]        in_rd,
  input  logic                 in_rd_we,
  output logic [AW-1:0]        rf_raddr1,
  output logic [AW-1:0]        rf_raddr2,
  input  logic [REG_WIDTH-1:0] rf_rdata1,
  input  logic [REG_WIDTH-1:0] rf_rdata2,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [REG_WIDTH-1:0] rf_wdata,
  input  logic                 wb_valid,
  input  logic [AW-1:0]        wb_rd,
  input  logic [REG_WIDTH-1:0] wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_WIDTH-1:0]  out_op,
  output logic [REG_WIDTH-1:0] out_a,
  output logic [REG_WIDTH-1:0] out_b,
  output logic [AW-1:0]        out_rd,
  output logic                 out_rd_we,
  output logic [REG_COUNT-1:0] busy_mask,
  output logic [15:0]          stall_cnt
);

  logic        ebusy_rs1, ebusy_rs2, ebusy_rd;
  logic        hazard, issue;
  issue_t      slot_q, slot_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;
  assign rf_we     = wb_valid;
  assign rf_waddr  = wb_rd;
  assign rf_wdata  = wb_data;

  scoreboard #(.REG_COUNT(REG_COUNT)) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (issue && in_rd_we),
    .set_idx   (in_rd),
    .clr_en    (wb_valid),
    .clr_idx   (wb_rd),
    .look_idx0 (in_rs1),
    .look_idx1 (in_rs2),
    .look_idx2 (in_rd),
    .ebusy0    (ebusy_rs1),
    .ebusy1    (ebusy_rs2),
    .ebusy2    (ebusy_rd),
    .busy_mask (busy_mask)
  );

  always_comb begin
    // The rd term blocks WAW so writebacks can never retire out of order
    hazard   = (in_uses_rs1 && ebusy_rs1) || (in_uses_rs2 && ebusy_rs2) ||
               (in_rd_we && ebusy_rd);
    in_ready = !hazard && (!out_valid_q || out_ready);
    issue    = in_valid && in_ready;

    slot_d      = slot_q;
    out_valid_d = out_valid_q;
    if (issue) begin
      out_valid_d  = 1'b1;
      slot_d.op    = in_op;
      slot_d.a     = (wb_valid && (wb_rd == in_rs1)) ? wb_data : rf_rdata1;
      slot_d.b     = (wb_valid && (wb_rd == in_rs2)) ? wb_data : rf_rdata2;
      slot_d.rd    = in_rd;
      slot_d.rd_we = in_rd_we;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      out_valid_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      slot_q      <= slot_d;
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op    = slot_q.op;
  assign out_a     = slot_q.a;
  assign out_b     = slot_q.b;
  assign out_rd    = slot_q.rd;
  assign out_rd_we = slot_q.rd_we;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed scenarios plus random traffic,
// checked against a pending-set / expected-transaction model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready;
  logic [7:0]  in_op;
  logic [3:0]  in_rs1, in_rs2, in_rd;
  logic        in_uses_rs1, in_uses_rs2, in_rd_we;
  logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [31:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic        rf_we;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_op;
  logic [31:0] out_a, out_b;
  logic [3:0]  out_rd;
  logic        out_rd_we;
  logic [15:0] busy_mask, stall_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic        rd_we;
  } exp_t;

  exp_t        q[$];
  bit          pend[16];
  int unsigned stall_m = 0;

  logic [31:0] bank[16] = '{default: '0};
  assign rf_rdata1 = bank[rf_raddr1];
  assign rf_rdata2 = bank[rf_raddr2];
  always @(posedge clk) if (rf_we) bank[rf_waddr] <= rf_wdata;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .busy_mask(busy_mask), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic eb(input logic [3:0] r);
    return pend[r] && !(wb_valid && wb_rd == r);
  endfunction

  function automatic logic [31:0] byp(input logic [3:0] r);
    return (wb_valid && wb_rd == r) ? wb_data : bank[r];
  endfunction

  // Monitor: compares whatever the output slot presents against the queue head.
  always begin
    @(negedge clk);
    if (rst_n) begin
      chk("out_valid", out_valid, q.size() != 0);
      if (out_valid && q.size() != 0) begin
        chk("out_op", out_op, q[0].op);
        chk("out_a", out_a, q[0].a);
        chk("out_b", out_b, q[0].b);
        chk("out_rd", out_rd, q[0].rd);
        chk("out_rd_we", out_rd_we, q[0].rd_we);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // Reference model: runs after the monitor so an empty queue means the slot frees this cycle.
  always begin
    logic hz, rdy;
    logic [15:0] vec;
    @(negedge clk);
    #1;
    if (!rst_n) begin
      q.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      stall_m = 0;
    end else begin
      vec = '0;
      foreach (pend[i]) vec[i] = pend[i];
      chk("busy_mask", busy_mask, vec);
      chk("stall_cnt", stall_cnt, 16'(stall_m));
      chk("rf_raddr1", rf_raddr1, in_rs1);
      chk("rf_raddr2", rf_raddr2, in_rs2);
      chk("rf_we", rf_we, wb_valid);
      if (wb_valid) begin
        chk("rf_waddr", rf_waddr, wb_rd);
        chk("rf_wdata", rf_wdata, wb_data);
      end
      hz  = (in_uses_rs1 && eb(in_rs1)) || (in_uses_rs2 && eb(in_rs2)) || (in_rd_we && eb(in_rd));
      rdy = !hz && (q.size() == 0);
      chk("in_ready", in_ready, rdy);
      if (in_valid && rdy) q.push_back('{in_op, byp(in_rs1), byp(in_rs2), in_rd, in_rd_we});
      if (in_valid && !rdy && stall_m < 65535) stall_m++;
      if (wb_valid) pend[wb_rd] = 1'b0;
      if (in_valid && rdy && in_rd_we) pend[in_rd] = 1'b1;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid = 0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_uses_rs1 = 0; in_uses_rs2 = 0; in_rd_we = 0;
    wb_valid = 0; wb_rd = '0; wb_data = '0; out_ready = 1;
  endtask

  task automatic set_instr(input logic [7:0] op, input logic [3:0] rs1, input logic u1,
                           input logic [3:0] rs2, input logic u2, input logic [3:0] rd,
                           input logic we);
    in_valid = 1; in_op = op; in_rs1 = rs1; in_uses_rs1 = u1;
    in_rs2 = rs2; in_uses_rs2 = u2; in_rd = rd; in_rd_we = we;
  endtask

  task automatic set_wb(input logic [3:0] r, input logic [31:0] d);
    wb_valid = 1; wb_rd = r; wb_data = d;
  endtask

  initial begin
    set_idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_fields", {out_op, out_a, out_b, out_rd, out_rd_we}, '0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_stall", stall_cnt, 0);

    // Load R2=5, R3=7 through the write port; these registers are not busy.
    set_wb(4'd2, 32'd5); cycle();
    set_idle(); set_wb(4'd3, 32'd7); cycle();
    set_idle(); set_instr(8'h11, 4'd2, 1, 4'd3, 1, 4'd9, 0); cycle();
    set_idle();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_a", out_a, 32'd5);
    chk("t1_out_b", out_b, 32'd7);
    chk("t1_busy", busy_mask, 0);
    cycle();

    // RAW stall on R4 resolved by a same-cycle bypassed writeback.
    set_instr(8'h22, 4'd0, 0, 4'd0, 0, 4'd4, 1); cycle();
    set_idle(); set_instr(8'h23, 4'd4, 1, 4'd1, 0, 4'd7, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t2_stall_ready", in_ready, 0);
      cycle();
    end
    chk("t2_stall_cnt", stall_cnt, 16'd3);
    set_wb(4'd4, 32'hDEAD);
    #1 chk("t2_bypass_ready", in_ready, 1);
    cycle();
    set_idle();
    chk("t2_out_a", out_a, 32'hDEAD);
    chk("t2_busy4", busy_mask[4], 0);
    cycle();

    // Writeback and new writer of R6 in the same cycle: set wins.
    set_instr(8'h31, 4'd0, 0, 4'd0, 0, 4'd6, 1); cycle();
    set_idle(); set_instr(8'h32, 4'd0, 0, 4'd0, 0, 4'd6, 1); set_wb(4'd6, 32'h66);
    #1 chk("t3_rf_we", {rf_we, rf_waddr}, {1'b1, 4'd6});
    cycle();
    set_idle();
    chk("t3_busy6", busy_mask[6], 1);
    set_wb(4'd6, 32'h67); cycle();

    // Backpressure: slot held for 3 cycles, then released and refilled in one cycle.
    set_idle(); set_instr(8'h41, 4'd2, 1, 4'd3, 1, 4'd8, 0); cycle();
    set_instr(8'h42, 4'd6, 1, 4'd2, 1, 4'd10, 0); out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_hold_ready", in_ready, 0);
      chk("t4_hold_op", out_op, 8'h41);
      cycle();
    end
    out_ready = 1;
    #1 chk("t4_release_ready", in_ready, 1);
    cycle();
    set_idle();
    chk("t4_next_op", out_op, 8'h42);
    cycle();

    // Long hazard on R5 to saturate the stall counter.
    set_instr(8'h51, 4'd0, 0, 4'd0, 0, 4'd5, 1); cycle();
    set_idle(); set_instr(8'h52, 4'd5, 1, 4'd0, 0, 4'd1, 0);
    repeat (70000) cycle();
    chk("t5_stall_sat", stall_cnt, 16'hFFFF);
    set_idle(); set_instr(8'h53, 4'd1, 1, 4'd2, 1, 4'd3, 0); cycle();
    set_idle(); set_instr(8'h54, 4'd5, 1, 4'd0, 0, 4'd1, 0); out_ready = 0;
    #2;
    chk("t6_pre_busy5", busy_mask[5], 1);
    chk("t6_pre_valid", out_valid, 1);
    rst_n = 0;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_busy", busy_mask, 0);
    chk("t6_async_stall", stall_cnt, 0);
    set_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int cand[$];
      set_idle();
      if ($urandom_range(3, 0) != 0) begin
        set_instr(8'($urandom), 4'($urandom_range(15, 0)), 1'($urandom),
                  4'($urandom_range(15, 0)), 1'($urandom),
                  4'($urandom_range(15, 0)), 1'($urandom));
      end
      foreach (pend[i]) if (pend[i]) cand.push_back(i);
      if ($urandom_range(1, 0) == 1) begin
        if (cand.size() != 0 && $urandom_range(3, 0) != 0)
          set_wb(4'(cand[$urandom_range(cand.size() - 1, 0)]), $urandom);
        else
          set_wb(4'($urandom_range(15, 0)), $urandom);
      end
      out_ready = ($urandom_range(3, 0) != 0);
      cycle();
    end
    set_idle();
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
